// File: rtl/sr_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared definitions for the SR-latch command debouncer: the controller state
// encoding and the default timing constants used as parameter defaults.
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_PULSE_CYCLES    = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SET,
    ST_CLR,
    ST_HOLDOFF
  } state_t;

endpackage

// File: rtl/sr_cmd_debouncer_if.sv
// -----------------------------------------------------------------------------
// sr_cmd_debouncer_if
// Bundles the raw push-button inputs and the latch-drive/status outputs.
//   set_btn, rst_btn : raw bouncing buttons (driven by master)
//   s_n, r_n         : active-low NAND SR latch drives (driven by slave)
//   q_shadow         : expected latch Q after the last completed command
//   busy             : controller not idle
//   err_conflict     : sticky, both requests arrived in the same cycle
// -----------------------------------------------------------------------------
interface sr_cmd_debouncer_if;

  logic set_btn;
  logic rst_btn;
  logic s_n;
  logic r_n;
  logic q_shadow;
  logic busy;
  logic err_conflict;

  modport master (
    output set_btn, rst_btn,
    input  s_n, r_n, q_shadow, busy, err_conflict
  );

  modport slave (
    input  set_btn, rst_btn,
    output s_n, r_n, q_shadow, busy, err_conflict
  );

endinterface

// File: rtl/sr_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// One button channel: 2-flop synchronizer, consecutive-sample debounce counter
// and rising-edge detector.
//   clk  : clock
//   rst  : synchronous active-high reset
//   btn  : raw asynchronous button
//   rise : one-cycle registered pulse when the debounced level goes 0 -> 1
// -----------------------------------------------------------------------------
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    prime;  // marks when sync2 carries a real post-reset sample
  logic          level;
  logic          armed;  // a low level has been seen since reset
  logic [CW-1:0] cnt;

  // A button held through reset release must not count as a press, so edges
  // are only reported once the channel has observed the button released.
  // NOTE: every register here uses <= so all of them sample the pre-edge
  // values; with = the synchronizer would collapse into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prime <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      rise  <= 1'b0;

      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2 & armed;
        if (!sync2) armed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (prime[1] && !sync2 && !level) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// sr_cmd_debouncer
// Debounces a "set" and a "reset" push-button and turns each press into a
// fixed-width active-low pulse on the matching input of a NAND SR latch.
// After reset the latch is forced cleared with an r_n pulse.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sr_cmd_debouncer_if.slave (buttons in, latch drives/status out)
// -----------------------------------------------------------------------------
module sr_cmd_debouncer
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEFAULT_PULSE_CYCLES
) (
  input logic               clk,
  input logic               rst,
  sr_cmd_debouncer_if.slave bus
);

  localparam int unsigned    PCW        = $clog2(PULSE_CYCLES + 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES);

  state_t         state;
  logic [PCW-1:0] pulse_cnt;
  logic           set_req;
  logic           clr_req;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.set_btn),
    .rise (set_req)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.rst_btn),
    .rise (clr_req)
  );

  // Outputs are updated on the same edge as the state they belong to, so
  // s_n/r_n/busy are flops. Only one of s_n/r_n is ever driven low: each is
  // lowered only on entry to its own pulse state and raised on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_INIT;
      pulse_cnt        <= '0;
      bus.s_n          <= 1'b1;
      bus.r_n          <= 1'b1;
      bus.q_shadow     <= 1'b0;
      bus.busy         <= 1'b1;
      bus.err_conflict <= 1'b0;
    end else begin
      case (state)
        // r_n is high while rst is held, so INIT counts its own pulse cycles.
        ST_INIT: begin
          if (pulse_cnt == PULSE_LAST) begin
            bus.r_n   <= 1'b1;
            pulse_cnt <= '0;
            state     <= ST_HOLDOFF;
          end else begin
            bus.r_n   <= 1'b0;
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (set_req && clr_req) begin
            bus.err_conflict <= 1'b1;
          end else if (set_req) begin
            state     <= ST_SET;
            bus.s_n   <= 1'b0;
            bus.busy  <= 1'b1;
            pulse_cnt <= PCW'(1);
          end else if (clr_req) begin
            state     <= ST_CLR;
            bus.r_n   <= 1'b0;
            bus.busy  <= 1'b1;
            pulse_cnt <= PCW'(1);
          end
        end

        // Entry already counted the first low cycle; pulse_cnt never exceeds
        // PULSE_CYCLES, so it cannot wrap.
        ST_SET: begin
          if (pulse_cnt == PULSE_LAST) begin
            bus.s_n      <= 1'b1;
            bus.q_shadow <= 1'b1;
            pulse_cnt    <= '0;
            state        <= ST_HOLDOFF;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        ST_CLR: begin
          if (pulse_cnt == PULSE_LAST) begin
            bus.r_n      <= 1'b1;
            bus.q_shadow <= 1'b0;
            pulse_cnt    <= '0;
            state        <= ST_HOLDOFF;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        ST_HOLDOFF: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= ST_INIT;
          bus.busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_debouncer
// Directed bench for sr_cmd_debouncer. Each expected latch pulse (kind and
// first low cycle) is queued when its stimulus is applied; a negedge monitor
// pops and compares it when the DUT lowers s_n or r_n, and checks its width.
// -----------------------------------------------------------------------------
module tb_sr_cmd_debouncer;

  localparam int D = 4;
  localparam int P = 2;

  typedef struct {
    logic is_set;
    int   cyc;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  cmd_t exp_q[$];

  sr_cmd_debouncer_if dut_if ();

  sr_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_set, input int c);
    cmd_t e;
    e.is_set = is_set;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_s = 1'b1;
  logic prev_r = 1'b1;
  int   s_start = -1;
  int   r_start = -1;

  task automatic take_pulse(input logic is_set);
    cmd_t e;
    check("pulse_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pulse_kind_is_set", is_set, e.is_set);
      check("pulse_start_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    check("s_r_not_both_low", !(dut_if.s_n === 1'b0 && dut_if.r_n === 1'b0), 1'b1);
    if (rst) begin
      s_start = -1;
      r_start = -1;
    end else begin
      if (prev_s && !dut_if.s_n) begin
        take_pulse(1'b1);
        s_start = cyc;
      end
      if (!prev_s && dut_if.s_n && s_start >= 0) begin
        check("set_pulse_len", cyc - s_start, P);
        s_start = -1;
      end
      if (prev_r && !dut_if.r_n) begin
        take_pulse(1'b0);
        r_start = cyc;
      end
      if (!prev_r && dut_if.r_n && r_start >= 0) begin
        check("clr_pulse_len", cyc - r_start, P);
        r_start = -1;
      end
    end
    prev_s = dut_if.s_n;
    prev_r = dut_if.r_n;
  end

  // ---------------- directed stimulus ----------------
  int t0;

  initial begin
    dut_if.set_btn = 1'b0;
    dut_if.rst_btn = 1'b0;
    rst = 1'b1;
    tick(3);

    // Reset values
    check("rst_s_n", dut_if.s_n, 1'b1);
    check("rst_r_n", dut_if.r_n, 1'b1);
    check("rst_q_shadow", dut_if.q_shadow, 1'b0);
    check("rst_err", dut_if.err_conflict, 1'b0);
    check("rst_busy", dut_if.busy, 1'b1);

    // Reset release: INIT r_n pulse, HOLDOFF, then idle
    rst = 1'b0;
    push(1'b0, cyc + 1);
    tick(1);
    check("init_r_n_low", dut_if.r_n, 1'b0);
    check("init_busy", dut_if.busy, 1'b1);
    tick(2);
    check("holdoff_r_n", dut_if.r_n, 1'b1);
    check("holdoff_busy", dut_if.busy, 1'b1);
    tick(1);
    check("idle_busy", dut_if.busy, 1'b0);
    check("idle_q_shadow", dut_if.q_shadow, 1'b0);

    // Clean set press: first low cycle is k+2+D with k = t0+1
    tick(3);
    dut_if.set_btn = 1'b1;
    t0 = cyc;
    push(1'b1, t0 + 3 + D);
    tick(D + 2);
    check("set_latency_not_yet", dut_if.s_n, 1'b1);
    tick(1);
    check("set_latency_low", dut_if.s_n, 1'b0);
    check("set_busy", dut_if.busy, 1'b1);
    tick(5);
    check("set_q_shadow", dut_if.q_shadow, 1'b1);
    check("set_done_busy", dut_if.busy, 1'b0);
    check("set_r_n_high", dut_if.r_n, 1'b1);
    dut_if.set_btn = 1'b0;
    tick(D + 6);

    // Short bounces never become a request
    for (int i = 0; i < 4; i++) begin
      dut_if.set_btn = (i % 2 == 0);
      tick(1);
      check("bounce_busy", dut_if.busy, 1'b0);
    end
    dut_if.set_btn = 1'b0;
    for (int i = 0; i < D + 6; i++) begin
      tick(1);
      check("bounce_settle_busy", dut_if.busy, 1'b0);
    end
    check("bounce_q_shadow", dut_if.q_shadow, 1'b1);

    // Clean reset press
    dut_if.rst_btn = 1'b1;
    push(1'b0, cyc + 3 + D);
    tick(12);
    check("clr_q_shadow", dut_if.q_shadow, 1'b0);
    check("clr_done_busy", dut_if.busy, 1'b0);
    dut_if.rst_btn = 1'b0;
    tick(D + 6);

    // Simultaneous presses: conflict, no pulse, sticky flag
    dut_if.set_btn = 1'b1;
    dut_if.rst_btn = 1'b1;
    tick(12);
    check("conflict_err", dut_if.err_conflict, 1'b1);
    check("conflict_busy", dut_if.busy, 1'b0);
    check("conflict_q_shadow", dut_if.q_shadow, 1'b0);
    dut_if.set_btn = 1'b0;
    dut_if.rst_btn = 1'b0;
    tick(D + 6);
    check("conflict_err_sticky", dut_if.err_conflict, 1'b1);

    // Reset request landing inside a SET pulse is dropped
    dut_if.set_btn = 1'b1;
    push(1'b1, cyc + 3 + D);
    tick(1);
    dut_if.rst_btn = 1'b1;
    tick(11);
    check("drop_q_shadow", dut_if.q_shadow, 1'b1);
    check("drop_busy", dut_if.busy, 1'b0);
    check("drop_err_sticky", dut_if.err_conflict, 1'b1);
    dut_if.set_btn = 1'b0;
    dut_if.rst_btn = 1'b0;
    tick(D + 6);
    check("drop_q_final", dut_if.q_shadow, 1'b1);

    // rst during a CLR pulse; rst_btn stays held through reset release
    dut_if.rst_btn = 1'b1;
    t0 = cyc;
    push(1'b0, t0 + 3 + D);
    tick(7);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    check("midrst_r_n", dut_if.r_n, 1'b1);
    check("midrst_s_n", dut_if.s_n, 1'b1);
    check("midrst_q_shadow", dut_if.q_shadow, 1'b0);
    check("midrst_err", dut_if.err_conflict, 1'b0);
    check("midrst_busy", dut_if.busy, 1'b1);
    tick(1);
    rst = 1'b0;
    push(1'b0, cyc + 1);
    tick(12);
    check("held_btn_busy", dut_if.busy, 1'b0);
    check("held_btn_q_shadow", dut_if.q_shadow, 1'b0);
    dut_if.rst_btn = 1'b0;
    tick(D + 6);
    dut_if.rst_btn = 1'b1;
    push(1'b0, cyc + 3 + D);
    tick(12);
    check("repress_busy", dut_if.busy, 1'b0);
    dut_if.rst_btn = 1'b0;
    tick(D + 6);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
